// File: rtl/rsa_pkg.sv
// ============================================================================
// rsa_pkg : shared types and constants for the rsa32 modexp sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package rsa_pkg;

   localparam int W = 32;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD     = 4'd1,
      SKIP     = 4'd2,
      SQ_REQ   = 4'd3,
      SQ_WAIT  = 4'd4,
      MUL_REQ  = 4'd5,
      MUL_WAIT = 4'd6,
      NEXT     = 4'd7,
      FIN      = 4'd8,
      DONE     = 4'd9
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_modexp_ctrl_if.sv
// ============================================================================
// rsa_modexp_ctrl_if : start/done handshake to the external modular multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

interface rsa_modexp_ctrl_if #(
   parameter int W = 32
);
   logic         mm_start;
   logic [W-1:0] mm_a;
   logic [W-1:0] mm_b;
   logic [W-1:0] mm_n;
   logic         mm_done;
   logic [W-1:0] mm_result;

   modport master (
      output mm_start, mm_a, mm_b, mm_n,
      input  mm_done, mm_result
   );

   modport slave (
      input  mm_start, mm_a, mm_b, mm_n,
      output mm_done, mm_result
   );
endinterface

`default_nettype wire

// File: rtl/rsa_modexp_ctrl_ltp.sv
// ============================================================================
// ltp : level-to-pulse converter, one-cycle pulse on each rising edge
// Rev 1.0
// ============================================================================
`default_nettype none

module ltp (
   input  wire logic i_clk,
   input  wire logic i_rstn,
   input  wire logic i_level,
   output logic      o_pulse
);
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_prev <= 1'b0;
      else         r_prev <= i_level;
   end

   assign o_pulse = i_level & ~r_prev;
endmodule

`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
// ============================================================================
// rsa_modexp_ctrl : left-to-right square-and-multiply sequencer for rsa32
// Rev 1.0
// ============================================================================
`default_nettype none

module rsa_modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int W  = rsa_pkg::W,
   parameter int CW = 6
) (
   input  wire logic         i_clk,
   input  wire logic         i_rstn,
   input  wire logic         i_start,
   input  wire logic [W-1:0] i_msg,
   input  wire logic [W-1:0] i_exp,
   input  wire logic [W-1:0] i_mod,
   rsa_modexp_ctrl_if.master mm,
   output logic [W-1:0]      o_result,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);
   localparam int IW = $clog2(W);

   state_t        r_state;
   logic [W-1:0]  r_r, r_m, r_e, r_n;
   logic [CW-1:0] r_idx;
   logic          r_mm_start;
   logic [W-1:0]  r_mm_a, r_mm_b, r_mm_n;
   logic [W-1:0]  r_result;
   logic          r_busy, r_done, r_err;
   logic          w_start_pulse;
   logic          w_ebit;

   ltp u_ltp (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_level (i_start),
      .o_pulse (w_start_pulse)
   );

   assign w_ebit = r_e[r_idx[IW-1:0]];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= IDLE;
         r_r        <= '0;
         r_m        <= '0;
         r_e        <= '0;
         r_n        <= '0;
         r_idx      <= '0;
         r_mm_start <= 1'b0;
         r_mm_a     <= '0;
         r_mm_b     <= '0;
         r_mm_n     <= '0;
         r_result   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_mm_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_pulse) begin
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_m   <= i_msg;
               r_e   <= i_exp;
               r_n   <= i_mod;
               r_err <= 1'b0;
               r_idx <= CW'(W-1);
               if (i_mod == '0) begin
                  r_err    <= 1'b1;
                  r_result <= '0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (i_exp == '0) begin
                  // x^0 is 1, except that 1 mod 1 is 0
                  r_result <= (i_mod == W'(1)) ? '0 : W'(1);
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_state <= SKIP;
               end
            end
            SKIP: begin
               if (w_ebit) begin
                  r_r <= r_m;
                  if (r_idx == '0) begin
                     r_state <= FIN;
                  end else begin
                     r_idx   <= r_idx - 1'b1;
                     r_state <= SQ_REQ;
                  end
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            SQ_REQ: begin
               r_mm_a     <= r_r;
               r_mm_b     <= r_r;
               r_mm_n     <= r_n;
               r_mm_start <= 1'b1;
               r_state    <= SQ_WAIT;
            end
            SQ_WAIT: begin
               if (mm.mm_done) begin
                  r_r     <= mm.mm_result;
                  r_state <= w_ebit ? MUL_REQ : NEXT;
               end
            end
            MUL_REQ: begin
               r_mm_a     <= r_r;
               r_mm_b     <= r_m;
               r_mm_n     <= r_n;
               r_mm_start <= 1'b1;
               r_state    <= MUL_WAIT;
            end
            MUL_WAIT: begin
               if (mm.mm_done) begin
                  r_r     <= mm.mm_result;
                  r_state <= NEXT;
               end
            end
            NEXT: begin
               if (r_idx == '0) begin
                  r_state <= FIN;
               end else begin
                  r_idx   <= r_idx - 1'b1;
                  r_state <= SQ_REQ;
               end
            end
            FIN: begin
               r_result <= r_r;
               r_done   <= 1'b1;
               r_state  <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mm.mm_start = r_mm_start;
   assign mm.mm_a     = r_mm_a;
   assign mm.mm_b     = r_mm_b;
   assign mm.mm_n     = r_mm_n;
   assign o_result    = r_result;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
// ============================================================================
// tb_rsa_modexp_ctrl : scoreboard bench with a variable-latency multiplier model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rsa_modexp_ctrl;
   typedef struct {
      logic [31:0] res;
      logic        err;
      int          ops_total;
   } sb_t;

   logic        clk;
   logic        rstn;
   logic        i_start;
   logic [31:0] i_msg, i_exp, i_mod;
   logic [31:0] o_result;
   logic        o_busy, o_done, o_err;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          ndone  = 0;
   int          opcnt  = 0;
   int          lat    = 3;
   logic        spur_req;

   sb_t         sb[$];
   logic [95:0] opq[$];

   logic        mm_done_m;
   logic [31:0] mm_res_m;
   logic        pend;
   int          cnt;
   logic [31:0] ca, cb, cn;

   rsa_modexp_ctrl_if #(.W(32)) mif ();

   rsa_modexp_ctrl #(.W(32), .CW(6)) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_start  (i_start),
      .i_msg    (i_msg),
      .i_exp    (i_exp),
      .i_mod    (i_mod),
      .mm       (mif.master),
      .o_result (o_result),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   assign mif.mm_done   = mm_done_m;
   assign mif.mm_result = mm_res_m;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Multiplier model: not reset, so a pending op can complete after a DUT reset
   initial begin
      mm_done_m = 1'b0;
      mm_res_m  = '0;
      pend      = 1'b0;
      cnt       = 0;
      ca = '0; cb = '0; cn = '0;
   end

   always @(negedge clk) begin
      logic [95:0] e;
      logic [63:0] p;
      mm_done_m = 1'b0;
      if (spur_req) begin
         mm_done_m = 1'b1;
         mm_res_m  = 32'hDEAD_BEEF;
      end
      if (mif.mm_start === 1'b1) begin
         opcnt++;
         ca = mif.mm_a; cb = mif.mm_b; cn = mif.mm_n;
         if (opq.size() == 0) begin
            check("op_unexpected", 96'd1, 96'd0);
         end else begin
            e = opq.pop_front();
            check("op_operands", {ca, cb, cn}, e);
         end
         pend = 1'b1;
         cnt  = lat;
      end else if (pend) begin
         if (cnt <= 1) begin
            p         = ({32'd0, ca} * {32'd0, cb}) % {32'd0, cn};
            mm_res_m  = p[31:0];
            mm_done_m = 1'b1;
            pend      = 1'b0;
         end else begin
            cnt--;
         end
      end
   end

   always @(negedge clk) begin
      sb_t s;
      if (o_done === 1'b1) begin
         ndone++;
         check("busy_at_done", {95'd0, o_busy}, 96'd1);
         if (sb.size() == 0) begin
            check("done_unexpected", 96'd1, 96'd0);
         end else begin
            s = sb.pop_front();
            check("result", {64'd0, o_result}, {64'd0, s.res});
            check("err", {95'd0, o_err}, {95'd0, s.err});
            check("op_count", 96'(opcnt), 96'(s.ops_total));
         end
      end
   end

   // Golden model: pushes expected operand triples and the final entry
   task automatic prep(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
      sb_t         s;
      logic [63:0] r;
      int          msb;
      int          nops;
      nops  = 0;
      s.err = 1'b0;
      if (n == 0) begin
         s.res = '0;
         s.err = 1'b1;
      end else if (e == 0) begin
         s.res = (n == 1) ? 32'd0 : 32'd1;
      end else begin
         msb = 31;
         while (!e[msb]) msb--;
         r = {32'd0, m};
         for (int i = msb - 1; i >= 0; i--) begin
            opq.push_back({r[31:0], r[31:0], n});
            r = (r * r) % {32'd0, n};
            nops++;
            if (e[i]) begin
               opq.push_back({r[31:0], m, n});
               r = (r * {32'd0, m}) % {32'd0, n};
               nops++;
            end
         end
         s.res = r[31:0];
      end
      s.ops_total = opcnt + nops;
      sb.push_back(s);
      i_msg = m;
      i_exp = e;
      i_mod = n;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int c;
      d0 = ndone;
      c  = 0;
      while (ndone == d0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      if (ndone == d0) check("done_timeout", 96'd0, 96'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0, o0, c;
      rstn     = 1'b0;
      i_start  = 1'b0;
      i_msg    = '0;
      i_exp    = '0;
      i_mod    = '0;
      spur_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", {64'd0, o_result}, 96'd0);
      check("rst_busy_done_err_start", {92'd0, o_busy, o_done, o_err, mif.mm_start}, 96'd0);
      check("rst_operands", {mif.mm_a, mif.mm_b, mif.mm_n}, 96'd0);
      rstn = 1'b1;

      // 5^3 mod 13
      o0 = opcnt;
      prep(32'd5, 32'd3, 32'd13);
      pulse_start();
      wait_done(500);
      check("t1_result_8", {64'd0, o_result}, 96'd8);
      check("t1_two_ops", 96'(opcnt - o0), 96'd2);

      // 4^13 mod 497
      o0 = opcnt;
      prep(32'd4, 32'd13, 32'd497);
      pulse_start();
      wait_done(500);
      check("t2_result_445", {64'd0, o_result}, 96'd445);
      check("t2_five_ops", 96'(opcnt - o0), 96'd5);

      // Exponent and modulus corner cases
      prep(32'd7, 32'd0, 32'd13);
      pulse_start();
      wait_done(100);
      check("e0_result_1", {64'd0, o_result}, 96'd1);
      prep(32'd0, 32'd0, 32'd1);
      pulse_start();
      wait_done(100);
      check("e0_n1_result_0", {64'd0, o_result}, 96'd0);
      o0 = opcnt;
      prep(32'd3, 32'd5, 32'd0);
      pulse_start();
      wait_done(100);
      repeat (5) @(posedge clk);
      #1;
      check("n0_err_sticky", {95'd0, o_err}, 96'd1);
      check("n0_no_ops", 96'(opcnt - o0), 96'd0);

      // Long SKIP with a stray done pulse and operand changes mid-job
      prep(32'd7, 32'd1, 32'd11);
      pulse_start();
      repeat (4) @(posedge clk);
      #1 spur_req = 1'b1;
      i_msg = 32'h1234_5678;
      i_exp = 32'hFFFF_FFFF;
      i_mod = 32'd3;
      @(posedge clk); #1 spur_req = 1'b0;
      wait_done(500);
      check("skip_spurious_result", {64'd0, o_result}, 96'd7);
      check("err_cleared", {95'd0, o_err}, 96'd0);

      // Top-bit exponent: 31 squarings, no multiplies
      lat = 1;
      o0  = opcnt;
      prep(32'd2, 32'h8000_0000, 32'hFFFF_FFFB);
      pulse_start();
      wait_done(2000);
      check("msb_31_squares", 96'(opcnt - o0), 96'd31);

      // Held / toggled start level yields one job; next clean edge yields another
      lat = 10;
      d0  = ndone;
      prep(32'd5, 32'd3, 32'd13);
      @(posedge clk); #1 i_start = 1'b1;
      repeat (4) @(posedge clk);
      #1 i_start = 1'b0;
      repeat (2) @(posedge clk);
      #1 i_start = 1'b1;
      repeat (2) @(posedge clk);
      #1 i_start = 1'b0;
      repeat (2) @(posedge clk);
      #1 i_start = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      check("held_one_job", 96'(ndone - d0), 96'd1);
      i_start = 1'b0;
      prep(32'd4, 32'd13, 32'd497);
      pulse_start();
      wait_done(1000);
      check("second_job", 96'(ndone - d0), 96'd2);

      // Reset while waiting on the multiply, late done after release
      lat = 20;
      o0  = opcnt;
      prep(32'd5, 32'd3, 32'd13);
      pulse_start();
      c = 0;
      while (opcnt < o0 + 2 && c < 500) begin
         @(posedge clk);
         c++;
      end
      if (opcnt < o0 + 2) check("mul_wait_timeout", 96'd0, 96'd1);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("abort_result", {64'd0, o_result}, 96'd0);
      check("abort_flags", {92'd0, o_busy, o_done, o_err, mif.mm_start}, 96'd0);
      check("abort_operands", {mif.mm_a, mif.mm_b, mif.mm_n}, 96'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      sb.delete();
      opq.delete();
      d0 = ndone;
      o0 = opcnt;
      repeat (60) @(posedge clk);
      #1;
      check("abort_no_done", 96'(ndone - d0), 96'd0);
      check("abort_no_ops", 96'(opcnt - o0), 96'd0);
      check("abort_idle", {95'd0, o_busy}, 96'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
